jtag_scan_ctrl: RTL

Host-side JTAG scan sequencer that drives a 16-state TAP controller through complete IR and DR scans from a single command. It owns TMS/TDI generation, keeps a shadow copy of the target TAP state in the standard 4-bit encoding, and captures TDO into a response word. It sits between a command source (CPU register block or test sequencer) and the JTAG pins. The target TAP advances on every CLK edge where `tck_en` is high.

---
 rtl/jtag_scan_ctrl_if.sv | 26 ++
 rtl/jtag_scan_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_ctrl_if.sv
// Command/response channel between a scan command source and jtag_scan_ctrl.
// The source drives cmd_* and receives cmd_ready plus the completion response.
interface jtag_scan_ctrl_if #(
  parameter int unsigned MAX_LEN = 32
) ();
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_ir;
  logic               cmd_reset;
  logic [LW-1:0]      cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_ir, cmd_reset, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_reset, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_scan_ctrl.sv
// Host-side JTAG scan sequencer: turns one command into a full IR/DR scan or TAP reset,
// keeps a shadow of the target TAP state and collects TDO into a response word.
module jtag_scan_ctrl #(
  parameter int unsigned MAX_LEN = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  jtag_scan_ctrl_if.slave  cmd,
  output logic             tck_en,
  output logic             tms,
  output logic             tdi,
  input  logic             tdo,
  output logic [3:0]       tap_state
);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned CW = LW + 3;
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [3:0] TapTlr   = 4'd15, TapRti   = 4'd12, TapSelDr = 4'd7,  TapCapDr = 4'd6;
  localparam logic [3:0] TapShDr  = 4'd2,  TapEx1Dr = 4'd1,  TapPauDr = 4'd3,  TapEx2Dr = 4'd0;
  localparam logic [3:0] TapUpdDr = 4'd5,  TapSelIr = 4'd4,  TapCapIr = 4'd14, TapShIr  = 4'd10;
  localparam logic [3:0] TapEx1Ir = 4'd9,  TapPauIr = 4'd11, TapEx2Ir = 4'd8,  TapUpdIr = 4'd13;

  typedef enum logic [2:0] {StInit, StIdle, StPre, StShift, StPost, StDone} state_e;

  state_e             st_q, st_d;
  logic [CW-1:0]      step_q, step_d, bit_q, bit_d, len_q, len_d;
  logic [CW-1:0]      pre_n, cmd_len_c;
  logic               ir_q, ir_d, rcmd_q, rcmd_d;
  logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, rsp_q, rsp_d;
  logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic               rdy_q, rdy_d, rv_q, rv_d;
  logic [3:0]         tap_q;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    unique case (s)
      TapTlr:   return m ? TapTlr   : TapRti;
      TapRti:   return m ? TapSelDr : TapRti;
      TapSelDr: return m ? TapSelIr : TapCapDr;
      TapCapDr: return m ? TapEx1Dr : TapShDr;
      TapShDr:  return m ? TapEx1Dr : TapShDr;
      TapEx1Dr: return m ? TapUpdDr : TapPauDr;
      TapPauDr: return m ? TapEx2Dr : TapPauDr;
      TapEx2Dr: return m ? TapUpdDr : TapShDr;
      TapUpdDr: return m ? TapSelDr : TapRti;
      TapSelIr: return m ? TapTlr   : TapCapIr;
      TapCapIr: return m ? TapEx1Ir : TapShIr;
      TapShIr:  return m ? TapEx1Ir : TapShIr;
      TapEx1Ir: return m ? TapUpdIr : TapPauIr;
      TapPauIr: return m ? TapEx2Ir : TapPauIr;
      TapEx2Ir: return m ? TapUpdIr : TapShIr;
      default:  return m ? TapSelDr : TapRti;
    endcase
  endfunction

  assign pre_n     = ir_q ? CW'(4) : CW'(3);
  assign cmd_len_c = (CW'(cmd.cmd_len) > CW'(MAX_LEN)) ? CW'(MAX_LEN) : CW'(cmd.cmd_len);

  // Each branch decides the step presented in the next cycle; st_q names the current one.
  always_comb begin
    st_d   = st_q;
    step_d = step_q;
    bit_d  = bit_q;
    len_d  = len_q;
    ir_d   = ir_q;
    rcmd_d = rcmd_q;
    data_d = data_q;
    cap_d  = cap_q;
    rsp_d  = rsp_q;
    tck_d  = 1'b0;
    tms_d  = 1'b0;
    tdi_d  = 1'b0;
    rdy_d  = 1'b0;
    rv_d   = 1'b0;
    unique case (st_q)
      StInit: begin
        if (step_q < CW'(6)) begin
          tck_d  = 1'b1;
          tms_d  = (step_q < CW'(5));
          step_d = step_q + CW'(1);
        end else if (rcmd_q) begin
          st_d  = StDone;
          rdy_d = 1'b1;
          rv_d  = 1'b1;
          rsp_d = '0;
        end else begin
          st_d  = StIdle;
          rdy_d = 1'b1;
        end
      end
      StIdle, StDone: begin
        rdy_d = 1'b1;
        st_d  = StIdle;
        if (cmd.cmd_valid) begin
          rdy_d  = 1'b0;
          ir_d   = cmd.cmd_ir;
          rcmd_d = cmd.cmd_reset;
          len_d  = cmd_len_c;
          data_d = cmd.cmd_data;
          cap_d  = '0;
          tck_d  = 1'b1;
          tms_d  = 1'b1;
          step_d = CW'(1);
          st_d   = cmd.cmd_reset ? StInit : StPre;
        end
      end
      StPre: begin
        tck_d = 1'b1;
        if (step_q < pre_n) begin
          // Capture step leaves straight to Exit1 when there is nothing to shift.
          if (step_q == pre_n - CW'(1)) tms_d = (len_q == '0);
          else                          tms_d = ir_q && (step_q == CW'(1));
          step_d = step_q + CW'(1);
        end else if (len_q == '0) begin
          st_d   = StPost;
          tms_d  = 1'b1;
          step_d = CW'(1);
        end else begin
          st_d   = StShift;
          bit_d  = '0;
          tms_d  = (len_q == CW'(1));
          tdi_d  = data_q[0];
          data_d = data_q >> 1;
        end
      end
      StShift: begin
        cap_d[bit_q[IW-1:0]] = tdo;
        tck_d = 1'b1;
        if (bit_q + CW'(1) < len_q) begin
          bit_d  = bit_q + CW'(1);
          tms_d  = (bit_q + CW'(2) == len_q);
          tdi_d  = data_q[0];
          data_d = data_q >> 1;
        end else begin
          st_d   = StPost;
          tms_d  = 1'b1;
          step_d = CW'(1);
        end
      end
      StPost: begin
        if (step_q < CW'(2)) begin
          tck_d  = 1'b1;
          step_d = step_q + CW'(1);
        end else begin
          st_d  = StDone;
          rdy_d = 1'b1;
          rv_d  = 1'b1;
          rsp_d = cap_q;
        end
      end
      default: st_d = StInit;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q   <= StInit;
      step_q <= '0;
      bit_q  <= '0;
      len_q  <= '0;
      ir_q   <= 1'b0;
      rcmd_q <= 1'b0;
      data_q <= '0;
      cap_q  <= '0;
      rsp_q  <= '0;
      tck_q  <= 1'b0;
      tms_q  <= 1'b1;
      tdi_q  <= 1'b0;
      rdy_q  <= 1'b0;
      rv_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      step_q <= step_d;
      bit_q  <= bit_d;
      len_q  <= len_d;
      ir_q   <= ir_d;
      rcmd_q <= rcmd_d;
      data_q <= data_d;
      cap_q  <= cap_d;
      rsp_q  <= rsp_d;
      tck_q  <= tck_d;
      tms_q  <= tms_d;
      tdi_q  <= tdi_d;
      rdy_q  <= rdy_d;
      rv_q   <= rv_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)      tap_q <= TapTlr;
    else if (tck_q) tap_q <= tap_next(tap_q, tms_q);
  end

  assign tck_en        = tck_q;
  assign tms           = tms_q;
  assign tdi           = tdi_q;
  assign tap_state     = tap_q;
  assign cmd.cmd_ready = rdy_q;
  assign cmd.rsp_valid = rv_q;
  assign cmd.rsp_data  = rsp_q;
endmodule
